// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   INSTR_W          instruction word width
//   DEFAULT_RESET_PC PC loaded on reset unless overridden
//   fetch_state_t    fetch FSM states
//   fetch_entry_t    prefetch buffer entry {pc, instr} at the default 32-bit address width
package fetch_pkg;

  localparam int unsigned INSTR_W          = 32;
  localparam int unsigned DEFAULT_ADDR_W   = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = '0;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0] pc;
    logic [INSTR_W-1:0]        instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO.
//   clk, reset (async, active low)
//   push/wr_data  write an entry
//   pop           remove the head entry
//   flush         empty the FIFO; overrides push and pop in the same cycle
//   count         number of stored entries (0..DEPTH)
//   head          oldest entry (undefined contents when count == 0)
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues single outstanding word reads to
// instruction memory, buffers returned words in a prefetch FIFO and hands
// them to decode with valid/ready. A redirect flushes everything in flight.
//   clk, reset (async, active low)
//   imem_req/imem_addr/imem_ack/imem_data   instruction memory port
//   redirect_valid/redirect_pc              taken jump from execute
//   out_valid/out_ready/out_instr/out_pc    decode handshake
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEFAULT_RESET_PC),
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);

  localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  fetch_state_t state, state_nxt;
  logic [ADDR_W-1:0]         pc;
  logic [ADDR_W-1:0]         held_addr;
  logic [CW-1:0]             count;
  logic [CW-1:0]             count_after;
  logic                      push;
  logic                      pop;
  logic [ADDR_W+INSTR_W-1:0] head;

  // A redirect voids both the fill and the drain of this cycle.
  assign push        = (state == REQ) && imem_ack && !redirect_valid;
  assign pop         = out_valid && out_ready && !redirect_valid;
  assign count_after = count + CW'(push) - CW'(pop);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (redirect_valid || (count < FULL)) state_nxt = REQ;
      REQ:
        if (redirect_valid)  state_nxt = imem_ack ? REQ : DISCARD;
        else if (imem_ack)   state_nxt = (count_after < FULL) ? REQ : IDLE;
      DISCARD:
        if (imem_ack) state_nxt = (redirect_valid || (count_after < FULL)) ? REQ : IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      held_addr <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (redirect_valid) pc <= redirect_pc;
      else if (push)      pc <= pc + 1'b1;
      // Snapshot of the address on the bus, so a killed request keeps its
      // address stable in DISCARD while pc already points at the target.
      if (state == REQ) held_addr <= pc;
    end
  end

  assign imem_req  = (state != IDLE);
  assign imem_addr = (state == DISCARD) ? held_addr : pc;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W + INSTR_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_valid),
    .wr_data ({pc, imem_data}),
    .count   (count),
    .head    (head)
  );

  assign out_valid           = (count != '0);
  assign {out_pc, out_instr} = out_valid ? head : '0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit. A behavioural memory answers reads
// with addr ^ 32'hA5A5_0000; a stream model tracks which PC decode must see
// next (increments per accepted instruction, jumps to the target on redirect).
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc;

  logic        w_req, w_ack, w_valid, w_ready;
  logic [31:0] w_addr, w_data, w_instr, w_pc;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .ADDR_W     (32),
    .RESET_PC   (32'h0),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .reset          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  instruction_fetch_unit #(
    .ADDR_W     (32),
    .RESET_PC   (32'hFFFF_FFFF),
    .FIFO_DEPTH (2)
  ) dut_wrap (
    .clk            (clk),
    .reset          (rst_n),
    .imem_req       (w_req),
    .imem_addr      (w_addr),
    .imem_ack       (w_ack),
    .imem_data      (w_data),
    .redirect_valid (w_redirect),
    .redirect_pc    (w_redirect_pc),
    .out_valid      (w_valid),
    .out_ready      (w_ready),
    .out_instr      (w_instr),
    .out_pc         (w_pc)
  );

  // Behavioural memories
  int unsigned lat       = 0;
  bit          rand_mode = 1'b0;
  logic        rnd_ack   = 1'b0;
  int unsigned mem_wait  = 0;

  assign imem_ack  = imem_req && (rand_mode ? rnd_ack : (mem_wait >= lat));
  assign imem_data = imem_addr ^ 32'hA5A5_0000;
  assign w_ack     = w_req;
  assign w_data    = w_addr ^ 32'hA5A5_0000;
  assign w_ready   = 1'b1;
  assign w_redirect    = 1'b0;
  assign w_redirect_pc = '0;

  always @(posedge clk) begin
    if (!imem_req || imem_ack) mem_wait <= 0;
    else                       mem_wait <= mem_wait + 1;
    rnd_ack <= ($urandom_range(0, 1) == 1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Stream model and per-cycle compare
  logic [31:0] exp_pc       = 32'h0;
  bit          expect_empty = 1'b0;
  bit          pend         = 1'b0;
  logic [31:0] pend_addr    = 32'h0;
  logic [31:0] got[$];
  logic [31:0] wq[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc       = 32'h0;
      expect_empty = 1'b0;
      pend         = 1'b0;
    end else begin
      if (pend) begin
        chk("req_held", {31'b0, imem_req}, 32'h1);
        chk("addr_stable", imem_addr, pend_addr);
      end
      if (expect_empty) chk("empty_after_redirect", {31'b0, out_valid}, 32'h0);
      expect_empty = 1'b0;
      if (out_valid) begin
        chk("stream_pc", out_pc, exp_pc);
        chk("stream_instr", out_instr, exp_pc ^ 32'hA5A5_0000);
        if (out_ready && !redirect_valid) begin
          got.push_back(out_pc);
          exp_pc = exp_pc + 1;
        end
      end else begin
        chk("idle_pc_zero", out_pc, 32'h0);
        chk("idle_instr_zero", out_instr, 32'h0);
      end
      if (redirect_valid) begin
        exp_pc       = redirect_pc;
        expect_empty = 1'b1;
      end
      pend      = imem_req && !imem_ack;
      pend_addr = imem_addr;
    end
  end

  always @(negedge clk) begin
    if (rst_n && w_valid && wq.size() < 4) begin
      wq.push_back(w_pc);
      chk("wrap_instr", w_instr, w_pc ^ 32'hA5A5_0000);
    end
  end

  function automatic logic [31:0] gq(input int unsigned i);
    return (i < got.size()) ? got[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_pending(input logic [31:0] addr, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step(1);
      if (imem_req && !imem_ack && imem_addr == addr) found = 1'b1;
    end
    chk(name, {31'b0, found}, 32'h1);
  endtask

  initial begin
    int unsigned base;
    int unsigned n0;
    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    step(3);
    chk("reset_req", {31'b0, imem_req}, 32'h0);
    chk("reset_valid", {31'b0, out_valid}, 32'h0);
    chk("reset_pc", out_pc, 32'h0);
    chk("reset_instr", out_instr, 32'h0);
    rst_n = 1'b1;

    // 1: zero-wait memory, continuous stream
    step(1);
    chk("t1_first_req", {31'b0, imem_req}, 32'h1);
    chk("t1_not_yet_valid", {31'b0, out_valid}, 32'h0);
    step(1);
    chk("t1_first_valid", {31'b0, out_valid}, 32'h1);
    chk("t1_first_pc", out_pc, 32'h0);
    chk("t1_first_instr", out_instr, 32'hA5A5_0000);
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("t1_throughput", {31'b0, out_valid}, 32'h1);
    end
    for (int unsigned i = 0; i < 4; i++) chk("t1_order", gq(i), i);

    // 2: 3-cycle ack latency -> one instruction every 4 cycles
    lat = 3;
    do_reset();
    step(10);
    n0 = got.size();
    step(40);
    chk("t2_rate", got.size() - n0, 32'd10);

    // 3: decode stalled, FIFO saturates, then drains in order
    lat = 0;
    out_ready = 1'b0;
    do_reset();
    step(12);
    chk("t3_req_off", {31'b0, imem_req}, 32'h0);
    chk("t3_valid", {31'b0, out_valid}, 32'h1);
    chk("t3_head", out_pc, 32'h0);
    base = got.size();
    out_ready = 1'b1;
    step(6);
    for (int unsigned i = 0; i < 3; i++) chk("t3_drain", gq(base + i), i);

    // 4: redirect while request for address 5 is pending
    lat = 3;
    do_reset();
    wait_pending(32'd5, "t4_pending_found");
    base = got.size();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step(1);
    redirect_valid = 1'b0;
    chk("t4_discard_addr", imem_addr, 32'h5);
    step(30);
    chk("t4_target", gq(base), 32'h40);
    chk("t4_next", gq(base + 1), 32'h41);

    // 5: redirect coinciding with ack and pop
    lat = 0;
    do_reset();
    step(6);
    chk("t5_ack_and_valid", {30'b0, imem_ack, out_valid}, 32'h3);
    base = got.size();
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    step(1);
    redirect_valid = 1'b0;
    chk("t5_flushed", {31'b0, out_valid}, 32'h0);
    step(6);
    chk("t5_target", gq(base), 32'h80);
    chk("t5_next", gq(base + 1), 32'h81);

    // Randomised memory timing, back-pressure and redirects
    rand_mode = 1'b1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom();
      step(1);
    end
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    rand_mode      = 1'b0;

    // 6: reset asserted in the middle of a request
    lat = 3;
    do_reset();
    wait_pending(32'd1, "t6_pending_found");
    rst_n = 1'b0;
    #1;
    chk("t6_req", {31'b0, imem_req}, 32'h0);
    chk("t6_addr", imem_addr, 32'h0);
    chk("t6_valid", {31'b0, out_valid}, 32'h0);
    chk("t6_pc", out_pc, 32'h0);
    chk("t6_instr", out_instr, 32'h0);
    step(2);
    rst_n = 1'b1;
    step(4);

    chk("wrap_first", (wq.size() > 0) ? wq[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    chk("wrap_second", (wq.size() > 1) ? wq[1] : 32'hDEAD_BEEF, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
